// File: rtl/tl_pkg.sv
// Shared types and constants for the highway/farm-road traffic-light controller.
package tl_pkg;

  localparam int unsigned TL_TW    = 4;
  localparam int unsigned TL_SW    = 2;
  localparam int unsigned TL_NLAMP = 6;

  typedef enum logic [TL_SW-1:0] {
    S_HG = 2'd0,
    S_HY = 2'd1,
    S_FG = 2'd2,
    S_FY = 2'd3
  } tl_state_t;

  // Bit positions of the lamps inside the internal lamp vector.
  localparam int unsigned L_HG = 5;
  localparam int unsigned L_HY = 4;
  localparam int unsigned L_HR = 3;
  localparam int unsigned L_FG = 2;
  localparam int unsigned L_FY = 1;
  localparam int unsigned L_FR = 0;

  localparam logic [TL_TW-1:0] TL_TMAX = '1;

endpackage

// File: rtl/tl_timer.sv
// Tick prescaler plus saturating phase timer; zero_i restarts the phase on a tick.
module tl_timer
  import tl_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic             zero_i,
  output logic             tick_c_o,
  output logic [TL_TW-1:0] cnt_o
);

  localparam int unsigned     PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic [TL_TW-1:0] cnt_q, cnt_d;

  assign tick_c_o = (pre_q == PRE_LAST);
  assign cnt_o    = cnt_q;

  // Clear beats hold; hold freezes both counters; otherwise advance on ticks.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (!hold_i) begin
      if (tick_c_o) begin
        pre_d = '0;
        if (zero_i) begin
          cnt_d = '0;
        end else if (cnt_q != TL_TMAX) begin
          cnt_d = cnt_q + TL_TW'(1);
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tl_ctrl_seq.sv
// Traffic-light controller: car-sensor synchronizer, phase FSM and Moore lamp decode.
module tl_ctrl_seq
  import tl_pkg::*;
#(
  parameter int unsigned LONG_TICKS  = 11,
  parameter int unsigned SHORT_TICKS = 3,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CLR,
  input  logic             TESTL,
  input  logic             CS,
  output logic [TL_TW-1:0] C3_Q,
  output logic [TL_SW-1:0] ST,
  output logic             HG,
  output logic             HY,
  output logic             HR,
  output logic             FG,
  output logic             FY,
  output logic             FR
);

  localparam logic [TL_TW-1:0] LONG_T  = TL_TW'(LONG_TICKS);
  localparam logic [TL_TW-1:0] SHORT_T = TL_TW'(SHORT_TICKS);

  logic [1:0]          sync_q;
  logic                cs_s;
  tl_state_t           state_q, state_d, state_nxt;
  logic                go_c, tick_c, hold_c;
  logic [TL_TW-1:0]    t_q;
  logic [TL_NLAMP-1:0] lamps_c;

  // Sensor synchronizer runs through clear and lamp test alike.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], CS};
    end
  end

  assign cs_s   = sync_q[1];
  assign hold_c = ~TESTL;

  tl_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk_i    (CLK),
    .rst_ni   (RESETN),
    .clr_i    (CLR),
    .hold_i   (hold_c),
    .zero_i   (go_c),
    .tick_c_o (tick_c),
    .cnt_o    (t_q)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_HG;
    end else begin
      state_q <= state_d;
    end
  end

  // go_c doubles as the timer restart so state and timer move on the same edge.
  always_comb begin
    state_d   = state_q;
    state_nxt = state_q;
    go_c      = 1'b0;
    unique case (state_q)
      S_HG: begin go_c = (t_q >= LONG_T) && cs_s;    state_nxt = S_HY; end
      S_HY: begin go_c = (t_q >= SHORT_T);           state_nxt = S_FG; end
      S_FG: begin go_c = (t_q >= LONG_T) || !cs_s;   state_nxt = S_FY; end
      S_FY: begin go_c = (t_q >= SHORT_T);           state_nxt = S_HG; end
    endcase
    if (CLR) begin
      state_d = S_HG;
    end else if (TESTL && tick_c && go_c) begin
      state_d = state_nxt;
    end
  end

  always_comb begin
    lamps_c = '0;
    unique case (state_q)
      S_HG: begin lamps_c[L_HG] = 1'b1; lamps_c[L_FR] = 1'b1; end
      S_HY: begin lamps_c[L_HY] = 1'b1; lamps_c[L_FR] = 1'b1; end
      S_FG: begin lamps_c[L_HR] = 1'b1; lamps_c[L_FG] = 1'b1; end
      S_FY: begin lamps_c[L_HR] = 1'b1; lamps_c[L_FY] = 1'b1; end
    endcase
    if (!TESTL) begin
      lamps_c = '1;
    end
  end

  assign C3_Q = t_q;
  assign ST   = state_q;
  assign HG   = lamps_c[L_HG];
  assign HY   = lamps_c[L_HY];
  assign HR   = lamps_c[L_HR];
  assign FG   = lamps_c[L_FG];
  assign FY   = lamps_c[L_FY];
  assign FR   = lamps_c[L_FR];

endmodule

// File: doc/tl_ctrl_seq.md
# tl_ctrl_seq

Sequential highway/farm-road traffic-light controller for the s400 benchmark family. It owns the 4-bit phase timer `C3_Q[3:0]` and the 2-bit phase state, and drives the six lamp outputs from them. It consumes the same control inputs that the extracted next-state cones read: `CLR`, `TESTL` and the car sensor. It is the registered counterpart the team uses to generate and check those cones in simulation.

## Interface
- `LONG_TICKS`, default 11: minimum green duration in ticks; legal range 1..15.
- `SHORT_TICKS`, default 3: yellow duration in ticks; legal range 1..15.
- `PRESCALE`, default 1: clock cycles per tick; legal range ≥1.
- `CLK` in 1: the single clock, rising edge.
- `RESETN` in 1: asynchronous, active-low reset.
- `CLR` in 1: synchronous clear.
- `TESTL` in 1: active-low lamp test.
- `CS` in 1: farm-road car sensor, asynchronous.
- `C3_Q` out 4: phase timer.
- `ST` out 2: phase state.
- `HG`, `HY`, `HR` out 1 each: highway green, yellow and red lamps.
- `FG`, `FY`, `FR` out 1 each: farm-road green, yellow and red lamps.

## Operation
- **States:** `S_HG`=0, `S_HY`=1, `S_FG`=2, `S_FY`=3.
- **Lamp decode (Moore):**
  - `S_HG` → `HG`,`FR`
  - `S_HY` → `HY`,`FR`
  - `S_FG` → `HR`,`FG`
  - `S_FY` → `HR`,`FY`
  - When `TESTL`=0, all six lamps are 1, regardless of state.
- **Car sensor:** `CS` passes through a 2-flop synchronizer; the output is `cs_s`. Only `cs_s` is used.
- **Prescaler:** counts 0..`PRESCALE`-1. A tick occurs on the cycle where the count = `PRESCALE`-1, and the count then wraps to 0. With `PRESCALE`=1, every cycle is a tick.
- **Transitions:** evaluated only on ticks; `t` = `C3_Q`.
  - `S_HG`→`S_HY` when `t` ≥ `LONG_TICKS` and `cs_s`=1.
  - `S_HY`→`S_FG` when `t` ≥ `SHORT_TICKS`.
  - `S_FG`→`S_FY` when `t` ≥ `LONG_TICKS` or `cs_s`=0.
  - `S_FY`→`S_HG` when `t` ≥ `SHORT_TICKS`.
- **Timer:** on a tick with a transition, `C3_Q`←0 on the same edge. On a tick without a transition, `C3_Q`←`C3_Q`+1, saturating at 15 (no wrap). The timer does not change between ticks.
- **Priority, highest first:**
  1. `RESETN`=0
  2. `CLR`=1
  3. `TESTL`=0
  4. normal operation
- **`CLR`=1:** `ST`←`S_HG`, `C3_Q`←0, prescaler←0. The synchronizer is not cleared.
- **`TESTL`=0 (with `CLR`=0):** state, timer and prescaler hold. The synchronizer keeps sampling.

## Timing
- **Reset:** `ST`=`S_HG`, `C3_Q`=0, prescaler=0, synchronizer=0. Lamps: `HG`=1, `FR`=1, others 0 (lamp test off). Reset takes effect immediately and asynchronously, including mid-phase.
- **Reset release:** operation starts on the first rising edge with `RESETN`=1.
- **Latencies:**
  - `CS` to `cs_s`: 2 cycles.
  - `ST` and `C3_Q` change only on rising edges.
  - Lamps follow `ST` combinationally, with 0-cycle latency from state.
- **Phase lengths:**
  - A phase with threshold N and its condition already true lasts exactly N+1 ticks: N increments, then the transition tick.
  - In `S_FG`, `cs_s`=0 exits on the next tick, independent of `t`.
- **Saturation:** `S_HG` with `cs_s`=0 indefinitely holds `C3_Q`=15.
- **Simultaneous events:**
  - `CLR` on a transition tick: the clear wins.
  - `TESTL` falling on a tick: no update on that edge.
  - `TESTL` rising: resumes from the held state and prescaler count.

## Structure
- **Package `tl_pkg`:**
  - state enum `tl_state_t` with the encodings above
  - `TL_TW`=4 (timer width)
  - lamp index constants
- **Sub-module `tl_timer`:** contains the prescaler, the saturating 4-bit timer and the tick output. Its inputs are `clr`, `hold` and `zero`.
- **Top level:** holds the synchronizer, the FSM and the lamp decode.

## Test plan
- **Reset and lamp test:** `RESETN` low, then `TESTL`=0 → `ST`=0, `C3_Q`=0, `HG`=`FR`=1 during reset. With `TESTL`=0, all lamps are 1. After `TESTL`=1, `HY`,`HR`,`FG`,`FY`=0.
- **Full cycle:** defaults, `CS`=1 from reset release → `HY` at edge 12. `FG` at edge 16. `FY` at edge 28, when `t` hits 11. `HG` at edge 32.
- **Early farm exit:** `CS`=0 issued 1 cycle after entering `S_FG` → `S_FY` 3 edges after the `CS` fall. `C3_Q` goes to 0.
- **Saturation:** `CS`=0 for 40 cycles → `ST`=`S_HG` and `C3_Q`=15 from edge 15 onward. Then `CS`=1 → `S_HY` 3 edges later.
- **Prescale:** `PRESCALE`=4, `CS`=1 → `C3_Q` steps every 4 cycles. `HY` at edge 48.
- **Clear and freeze:** `TESTL`=0 at `C3_Q`=5 for 10 cycles → `C3_Q` stays 5 and `ST` holds. `CLR`=1 asserted mid-`S_FG` together with a due transition → next edge `ST`=`S_HG`, `C3_Q`=0.
